// File: rtl/alu_pkg.sv
// Shared ALU definitions: selector codes, RV32I opcodes and the issue entry.
package alu_pkg;

    localparam logic [3:0] ADD       = 4'd0;
    localparam logic [3:0] SUB       = 4'd1;
    localparam logic [3:0] AND       = 4'd2;
    localparam logic [3:0] OR        = 4'd3;
    localparam logic [3:0] XOR       = 4'd4;
    localparam logic [3:0] SLL       = 4'd5;
    localparam logic [3:0] SLR       = 4'd6;
    localparam logic [3:0] SLT       = 4'd7;
    localparam logic [3:0] SLTU      = 4'd8;
    localparam logic [3:0] SRA       = 4'd9;
    localparam logic [3:0] OPERAND_B = 4'd15;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        illegal;
    } issue_entry_t;

    // funct3 mapping shared by OP and OP-IMM; shift/sub variants resolved by caller
    function automatic logic [3:0] f3_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_sel = ADD;
            3'b001:  f3_sel = SLL;
            3'b010:  f3_sel = SLT;
            3'b011:  f3_sel = SLTU;
            3'b100:  f3_sel = XOR;
            3'b101:  f3_sel = SLR;
            3'b110:  f3_sel = OR;
            default: f3_sel = AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder producing one issue entry.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]  i_instr,
    input  logic [31:0]  i_rs1,
    input  logic [31:0]  i_rs2,
    input  logic [31:0]  i_pc,
    output issue_entry_t o_entry
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_immi;
    logic [31:0] w_immu;
    logic        w_ok;
    logic [3:0]  w_sel;
    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_op   = i_instr[6:0];
    assign w_f3   = i_instr[14:12];
    assign w_f7   = i_instr[31:25];
    assign w_immi = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_immu = {i_instr[31:12], 12'b0};

    always_comb begin
        w_ok  = 1'b0;
        w_sel = ADD;
        w_a   = '0;
        w_b   = '0;
        case (w_op)
            OP: begin
                w_a = i_rs1;
                w_b = i_rs2;
                w_sel = f3_sel(w_f3);
                if (w_f3 == 3'b000 || w_f3 == 3'b101) begin
                    w_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    if (w_f7 == 7'b0100000)
                        w_sel = (w_f3 == 3'b000) ? SUB : SRA;
                end else begin
                    w_ok = (w_f7 == 7'b0000000);
                end
            end
            OP_IMM: begin
                w_a = i_rs1;
                w_b = w_immi;
                w_sel = f3_sel(w_f3);
                if (w_f3 == 3'b001) begin
                    w_ok = (w_f7 == 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    if (w_f7 == 7'b0100000)
                        w_sel = SRA;
                end else begin
                    w_ok = 1'b1;
                end
            end
            LUI: begin
                w_ok  = 1'b1;
                w_b   = w_immu;
                w_sel = OPERAND_B;
            end
            AUIPC: begin
                w_ok  = 1'b1;
                w_a   = i_pc;
                w_b   = w_immu;
                w_sel = ADD;
            end
            default: w_ok = 1'b0;
        endcase
    end

    // Illegal entries are zeroed so nothing downstream can act on stale fields
    always_comb begin
        o_entry = '0;
        if (w_ok) begin
            o_entry.a   = w_a;
            o_entry.b   = w_b;
            o_entry.sel = w_sel;
            o_entry.rd  = i_instr[11:7];
        end else begin
            o_entry.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a 2-entry skid buffer with registered in_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_operations_selector,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]   r_state;
    logic         r_in_ready;
    issue_entry_t r_main;
    issue_entry_t r_skid;
    issue_entry_t w_dec;
    logic         w_accept;
    logic         w_consume;

    alu_decode u_dec (
        .i_instr (in_instr),
        .i_rs1   (in_rs1_data),
        .i_rs2   (in_rs2_data),
        .i_pc    (in_pc),
        .o_entry (w_dec)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_dec;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_consume) begin
                        r_skid     <= w_dec;
                        r_state    <= S_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_main <= w_dec;
                    end else if (w_consume) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_consume) begin
                        r_main     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready                = r_in_ready;
    assign out_valid               = (r_state != S_EMPTY);
    assign operand_a               = r_main.a;
    assign operand_b               = r_main.b;
    assign alu_operations_selector = r_main.sel;
    assign out_rd                  = r_main.rd;
    assign out_illegal             = r_main.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that produces the ALU's input interface: `operand_a`, `operand_b` and a 4-bit `alu_operations_selector`.
- Accepts RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC) together with register-file read data and the PC.
- Decodes them into the ALU selector encoding and registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between register read and the ALU/execute stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- in_rs1_data  input  32  rs1 value.
- in_rs2_data  input  32  rs2 value.
- in_pc  input  32  instruction PC.
- out_valid  output  1  issue entry is valid.
- out_ready  input  1  ALU/execute consumes the entry.
- operand_a  output  32  ALU operand A.
- operand_b  output  32  ALU operand B.
- alu_operations_selector  output  4  ALU op.
- out_rd  output  5  destination register.
- out_illegal  output  1  entry is not a legal ALU instruction.

Behaviour:
- Selector encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SLR=6, SLT=7, SLTU=8, SRA=9, OPERAND_B=15. Codes 10–14 are never produced.
- OP (0110011):
  - a=rs1, b=rs2.
  - funct3 000 gives ADD when funct7=0000000 and SUB when funct7=0100000.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101 gives SLR when funct7=0000000 and SRA when funct7=0100000.
  - Any other funct7 is illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended I-immediate.
  - funct3 mapping as for OP, with no SUB.
  - Shifts: imm[11:5] must be 0000000, or 0100000 for SRAI only; otherwise illegal.
  - For shifts, operand_b is the full sign-extended immediate; the ALU uses b[4:0].
- LUI (0110111): a=0, b={instr[31:12],12'b0}, sel=OPERAND_B.
- AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, sel=ADD.
- Any other opcode, or instr[1:0]≠11, is illegal.
- Illegal entries:
  - Still flow through the buffer, with out_illegal=1, sel=ADD, operands=0, rd=0.
  - No stall or drop.
- rd: instr[11:7] for legal entries.
- Buffer: 2 entries (main drives outputs, skid holds overflow). States EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE, accept without consume → TWO.
  - ONE, consume without accept → EMPTY.
  - ONE, accept and consume → ONE; the new entry goes into main.
  - TWO, consume → ONE; skid moves to main.
  - TWO never accepts.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. There is no combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1). That is 1 cycle, with no bubbles at full throughput.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals and operands hold stable.
- Ordering is strictly FIFO.
- flush: next state EMPTY, in_ready=1, and the same-cycle input is discarded. flush has priority over accept and consume.
- Reset: asynchronous to EMPTY. out_valid=0, in_ready=1, operand_a=0, operand_b=0, alu_operations_selector=0, out_rd=0, out_illegal=0.
- Reset asserted mid-transfer discards all entries.
- Data registers hold their value when out_valid=0. The consumer must ignore them.

Decomposition:
- Shared package alu_pkg holds:
  - selector localparams ADD..SRA and OPERAND_B;
  - opcode constants OP, OP_IMM, LUI, AUIPC;
  - issue_entry_t struct {a, b, sel, rd, illegal}.
- alu_pkg is imported by this block and the ALU.
- One combinational sub-module: alu_decode (instr, rs1, rs2, pc → issue_entry_t). The skid buffer stays in the top module.

Test Plan:
- R-type SUB (funct7=0100000, funct3=000, rs1=10, rs2=3), out_ready=1 → next cycle out_valid=1, sel=1, a=10, b=3, rd=instr[11:7], illegal=0.
- SRAI (imm=0x403, rs1=0x80000000) → sel=9, b=0x00000403. SRAI with imm[11:5]=0100001 → illegal=1, sel=0, a=b=0.
- LUI 0x12345 → sel=15, a=0, b=0x12345000. AUIPC 0xFFFFF at pc=0x100 → sel=0, a=0x100, b=0xFFFFF000.
- Backpressure: hold out_ready=0 and send 3 instructions → first 2 accepted, in_ready=0 after the second, outputs frozen on entry 1. Release → entries appear in order, and in_ready returns 1 one cycle after the first consume.
- Streaming: in_valid=out_ready=1 for 10 cycles → 10 issues in 10 consecutive cycles, FIFO order.
- flush asserted in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1. Deassert rst_n asynchronously mid-stream → outputs go to reset values immediately, without waiting for a clock.
